// File: rtl/sopc_data_bus_if.sv
// Bus bundle between the CPU data port, the data-side interconnect and its slaves.
// master: the interconnect's view; slave: the CPU and slave devices around it.
interface sopc_data_bus_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic                         m_ce_i;
  logic                         m_we_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [SEL_W-1:0]             m_sel_i;
  logic [DATA_W-1:0]            m_wdata_i;
  logic [DATA_W-1:0]            m_rdata_o;
  logic                         m_stall_o;
  logic                         m_err_o;
  logic [NUM_SLAVES-1:0]        s_ce_o;
  logic                         s_we_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [SEL_W-1:0]             s_sel_o;
  logic [DATA_W-1:0]            s_wdata_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;

  modport master (
    input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_wdata_i, s_rdata_i, s_ack_i,
    output m_rdata_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o
  );

  modport slave (
    output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_wdata_i, s_rdata_i, s_ack_i,
    input  m_rdata_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o
  );
endinterface

// File: rtl/sopc_data_bus.sv
// Data-side interconnect: decodes CPU accesses onto base/mask slave windows, waits
// for the selected slave's ack, and reports unmapped or timed-out accesses as errors.
module sopc_data_bus #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h1000_0000, 32'h0000_4000, 32'h0000_2000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000},
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned TO_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  sopc_data_bus_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [TO_W-1:0]       cnt;
  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] hit_onehot;
  logic                  hit_any;
  logic                  ack_sel;
  logic [DATA_W-1:0]     rdata_masked [NUM_SLAVES];
  logic [DATA_W-1:0]     rdata_sel;

  // Window match per slave; the selected slave's read data is AND-OR muxed by s_ce_o.
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slave
    assign match[k] = bus.m_ce_i &
      ((bus.m_addr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W]);
    assign rdata_masked[k] = bus.s_rdata_i[k*DATA_W +: DATA_W] & {DATA_W{bus.s_ce_o[k]}};
  end

  // Isolating the lowest set bit gives lowest-index priority for overlapping windows.
  assign hit_onehot = match & (~match + NUM_SLAVES'(1));
  assign hit_any    = |match;
  assign ack_sel    = |(bus.s_ack_i & bus.s_ce_o);

  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rdata_sel = rdata_sel | rdata_masked[k];
    end
  end

  assign bus.m_stall_o = (state == ACCESS) || ((state == IDLE) && bus.m_ce_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.s_ce_o    <= '0;
      bus.s_we_o    <= 1'b0;
      bus.s_addr_o  <= '0;
      bus.s_sel_o   <= '0;
      bus.s_wdata_o <= '0;
      bus.m_rdata_o <= '0;
      bus.m_err_o   <= 1'b0;
    end else begin
      bus.m_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.m_ce_i) begin
            if (hit_any) begin
              bus.s_we_o    <= bus.m_we_i;
              bus.s_addr_o  <= bus.m_addr_i;
              bus.s_sel_o   <= bus.m_sel_i;
              bus.s_wdata_o <= bus.m_wdata_i;
              bus.s_ce_o    <= hit_onehot;
              cnt           <= '0;
              state         <= ACCESS;
            end else begin
              bus.m_err_o <= 1'b1;
              state       <= DONE;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the timeout cycle still completes the access cleanly.
          if (ack_sel) begin
            bus.m_rdata_o <= rdata_sel;
            bus.s_ce_o    <= '0;
            state         <= DONE;
          end else if (cnt == TO_W'(TIMEOUT)) begin
            bus.m_rdata_o <= '0;
            bus.s_ce_o    <= '0;
            bus.m_err_o   <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_ce_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.s_ce_o));
  a_ce_access: assert property (@(posedge clk) disable iff (rst)
                                ((state == ACCESS) == (bus.s_ce_o != '0)));

endmodule

// File: tb/tb_sopc_data_bus.sv
// Randomised bench for sopc_data_bus: two instances (default windows and an overlapping
// window set) driven one at a time, checked each cycle against a transaction-level model.
module tb_sopc_data_bus;

  localparam logic [127:0] BASE0 = {32'h1000_0000, 32'h0000_4000, 32'h0000_2000, 32'h0000_0000};
  localparam logic [127:0] MASK0 = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000};
  localparam logic [127:0] BASE1 = BASE0;
  localparam logic [127:0] MASK1 = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_C000};
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cur;
  logic         ce, we;
  logic [31:0]  addr, wdata;
  logic [3:0]   sel;
  logic [127:0] srd;
  logic [3:0]   sack;

  sopc_data_bus_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus0 ();
  sopc_data_bus_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus1 ();

  sopc_data_bus #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SLAVE_BASE(BASE0),
                  .SLAVE_MASK(MASK0), .TIMEOUT(TMO), .TO_W(4))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sopc_data_bus #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SLAVE_BASE(BASE1),
                  .SLAVE_MASK(MASK1), .TIMEOUT(TMO), .TO_W(4))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.m_ce_i = ce & ~cur;
  assign bus1.m_ce_i = ce & cur;
  assign bus0.m_we_i = we;     assign bus1.m_we_i = we;
  assign bus0.m_addr_i = addr; assign bus1.m_addr_i = addr;
  assign bus0.m_sel_i = sel;   assign bus1.m_sel_i = sel;
  assign bus0.m_wdata_i = wdata; assign bus1.m_wdata_i = wdata;
  assign bus0.s_rdata_i = srd; assign bus1.s_rdata_i = srd;
  assign bus0.s_ack_i = sack;  assign bus1.s_ack_i = sack;

  logic        a_stall, a_err, a_swe;
  logic [3:0]  a_ce, a_ssel;
  logic [31:0] a_rdata, a_saddr, a_swdata;
  assign a_stall  = cur ? bus1.m_stall_o : bus0.m_stall_o;
  assign a_err    = cur ? bus1.m_err_o   : bus0.m_err_o;
  assign a_ce     = cur ? bus1.s_ce_o    : bus0.s_ce_o;
  assign a_rdata  = cur ? bus1.m_rdata_o : bus0.m_rdata_o;
  assign a_swe    = cur ? bus1.s_we_o    : bus0.s_we_o;
  assign a_saddr  = cur ? bus1.s_addr_o  : bus0.s_addr_o;
  assign a_ssel   = cur ? bus1.s_sel_o   : bus0.s_sel_o;
  assign a_swdata = cur ? bus1.s_wdata_o : bus0.s_wdata_o;

  int total = 0;
  int bad = 0;

  // Model state: what the CPU should see and what the slaves should see latched.
  logic        exp_stall, exp_err, exp_done;
  logic [3:0]  exp_ce;
  logic [31:0] md_rdata, md_addr, md_wdata;
  logic [3:0]  md_sel;
  logic        md_we;

  int          n_stall, n_ce, n_err;
  logic [3:0]  ce_seen;
  logic [31:0] done_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cfg=%0d t=%0t: actual=%0h required=%0h", name, cur, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] win_base(input int k);
    logic [127:0] v;
    v = cur ? BASE1 : BASE0;
    return v[k*32 +: 32];
  endfunction

  function automatic logic [31:0] win_mask(input int k);
    logic [127:0] v;
    v = cur ? MASK1 : MASK0;
    return v[k*32 +: 32];
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++) begin
      if ((a & win_mask(k)) == win_base(k)) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_rdata = '0; md_addr = '0; md_wdata = '0; md_sel = '0; md_we = 1'b0;
  endtask

  // Compare all outputs at the negedge, then advance to just after the next posedge.
  task automatic cycle();
    @(negedge clk);
    chk("m_stall", 64'(a_stall), 64'(exp_stall));
    chk("m_err", 64'(a_err), 64'(exp_err));
    chk("s_ce", 64'(a_ce), 64'(exp_ce));
    chk("m_rdata", 64'(a_rdata), 64'(md_rdata));
    chk("s_we", 64'(a_swe), 64'(md_we));
    chk("s_addr", 64'(a_saddr), 64'(md_addr));
    chk("s_sel", 64'(a_ssel), 64'(md_sel));
    chk("s_wdata", 64'(a_swdata), 64'(md_wdata));
    if (a_stall) n_stall++;
    if (a_ce != 4'b0) n_ce++;
    if (a_err) n_err++;
    ce_seen = ce_seen | a_ce;
    if (exp_done) done_rdata = a_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rdata(input int k, input logic [31:0] d, input bit put);
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = (put && j == k) ? d : $urandom;
    srd = v;
  endtask

  task automatic idle_cycle();
    ce = 1'b0; sack = 4'($urandom);
    drive_rdata(0, 32'h0, 1'b0);
    exp_stall = 1'b0; exp_err = 1'b0; exp_ce = 4'b0; exp_done = 1'b0;
    cycle();
  endtask

  // One CPU access; lat = ACCESS cycle index of the ack, or <0 / >TMO for a dead slave.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input int lat, input logic [31:0] data,
                         input bit rnd_noise, input logic [3:0] fixed_noise);
    int k;
    int n_acc;
    bit acked;
    logic [3:0] oh;
    logic [3:0] nz;
    k = decode(a);
    oh = (k >= 0) ? (4'b0001 << k) : 4'b0000;
    n_stall = 0; n_ce = 0; n_err = 0; ce_seen = 4'b0; done_rdata = 32'hx;
    acked = (lat >= 0) && (lat <= TMO);
    n_acc = acked ? lat + 1 : TMO + 1;

    ce = 1'b1; we = w; addr = a; sel = s; wdata = wd;
    sack = 4'($urandom); drive_rdata(0, 32'h0, 1'b0);
    exp_stall = 1'b1; exp_err = 1'b0; exp_ce = 4'b0; exp_done = 1'b0;
    cycle();

    if (k >= 0) begin
      md_we = w; md_addr = a; md_sel = s; md_wdata = wd;
      for (int i = 0; i < n_acc; i++) begin
        nz = rnd_noise ? 4'($urandom) : fixed_noise;
        sack = (nz & ~oh) | ((i == lat) ? oh : 4'b0);
        drive_rdata(k, data, i == lat);
        exp_stall = 1'b1; exp_err = 1'b0; exp_ce = oh;
        cycle();
      end
      md_rdata = acked ? data : 32'h0;
      exp_err = !acked;
    end else begin
      exp_err = 1'b1;
    end

    // Inputs during DONE must be ignored, so drive junk.
    ce = 1'($urandom); we = 1'($urandom); addr = $urandom; sel = 4'($urandom); wdata = $urandom;
    sack = 4'($urandom); drive_rdata(0, 32'h0, 1'b0);
    exp_stall = 1'b0; exp_ce = 4'b0; exp_done = 1'b1;
    cycle();
    exp_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r;
    logic [31:0] a;
    rst = 1'b1; cur = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    srd = '0; sack = '0;
    model_reset();
    exp_stall = 1'b0; exp_err = 1'b0; exp_ce = 4'b0; exp_done = 1'b0;
    n_stall = 0; n_ce = 0; n_err = 0; ce_seen = 4'b0; done_rdata = '0;
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;

    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        cur = 1'b1; rst = 1'b1; ce = 1'b0;
        model_reset();
        exp_stall = 1'b0; exp_err = 1'b0; exp_ce = 4'b0; exp_done = 1'b0;
        cycle();
        rst = 1'b0;
      end

      if (c == 0) begin
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 4'b0);
        chk("t1_stall_cycles", 64'(n_stall), 64'd2);
        chk("t1_ce_cycles", 64'(n_ce), 64'd1);
        chk("t1_ce_onehot", 64'(ce_seen), 64'b0001);
        chk("t1_rdata", 64'(done_rdata), 64'hDEAD_BEEF);
        chk("t1_err_pulses", 64'(n_err), 64'd0);
        idle_cycle();

        run_txn(1'b1, 32'h1000_0004, 4'b0011, 32'h1234_5678, 3, 32'h0BAD_0002, 1'b1, 4'b0);
        chk("t2_stall_cycles", 64'(n_stall), 64'd5);
        chk("t2_ce_cycles", 64'(n_ce), 64'd4);
        chk("t2_ce_onehot", 64'(ce_seen), 64'b1000);

        run_txn(1'b0, 32'h8000_0000, 4'hF, 32'h0, 0, 32'h0, 1'b1, 4'b0);
        chk("t3_stall_cycles", 64'(n_stall), 64'd1);
        chk("t3_ce_cycles", 64'(n_ce), 64'd0);
        chk("t3_err_pulses", 64'(n_err), 64'd1);
        chk("t3_rdata_held", 64'(done_rdata), 64'h0BAD_0002);
        idle_cycle();

        run_txn(1'b0, 32'h0000_2000, 4'hF, 32'h0, -1, 32'h0, 1'b1, 4'b0);
        chk("t4_ce_cycles", 64'(n_ce), 64'd16);
        chk("t4_ce_onehot", 64'(ce_seen), 64'b0010);
        chk("t4_err_pulses", 64'(n_err), 64'd1);
        chk("t4_rdata_zero", 64'(done_rdata), 64'h0);

        run_txn(1'b0, 32'h0000_4008, 4'hF, 32'h0, 15, 32'h7777_1111, 1'b1, 4'b0);
        chk("tmo_ack_wins_err", 64'(n_err), 64'd0);
        chk("tmo_ack_wins_stall", 64'(n_stall), 64'd17);
        chk("tmo_ack_wins_rdata", 64'(done_rdata), 64'h7777_1111);

        // Reset during the second ACCESS cycle of a read to slave 0.
        ce = 1'b1; we = 1'b0; addr = 32'h0000_0100; sel = 4'hF; wdata = 32'h0; sack = 4'b0;
        exp_stall = 1'b1; exp_err = 1'b0; exp_ce = 4'b0; exp_done = 1'b0;
        cycle();
        md_we = 1'b0; md_addr = 32'h0000_0100; md_sel = 4'hF; md_wdata = 32'h0;
        exp_ce = 4'b0001;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; ce = 1'b0;
        model_reset();
        exp_stall = 1'b0; exp_err = 1'b0; exp_ce = 4'b0;
        cycle();
        run_txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 2, 32'hCAFE_F00D, 1'b1, 4'b0);
        chk("t6_rdata", 64'(done_rdata), 64'hCAFE_F00D);
        chk("t6_stall_cycles", 64'(n_stall), 64'd4);
      end else begin
        run_txn(1'b0, 32'h0000_2004, 4'hF, 32'h0, 1, 32'h5555_AAAA, 1'b0, 4'b0100);
        chk("t5_ce_onehot", 64'(ce_seen), 64'b0001);
        chk("t5_stall_cycles", 64'(n_stall), 64'd3);
        chk("t5_rdata", 64'(done_rdata), 64'h5555_AAAA);
      end

      for (int t = 0; t < 120; t++) begin
        r = $urandom_range(0, 4);
        if (r == 4) a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
        else        a = win_base(r) | ($urandom & ~win_mask(r));
        case ($urandom_range(0, 9))
          6:       lat = 14;
          7:       lat = 15;
          8:       lat = -1;
          9:       lat = $urandom_range(5, 12);
          default: lat = $urandom_range(0, 4);
        endcase
        run_txn(1'($urandom), a, 4'($urandom), $urandom, lat, $urandom, 1'b1, 4'b0);
        for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
